// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Byte-serial RAM arbiter for instruction-fetch and data ports.
// Revision : 1.0
// ============================================================================
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [2:0]        mem_len,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_i, w_i_nxt, r_len, w_len_nxt, w_i_inc, w_mem_n;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt, w_next_a, w_ram_a_nxt;
    logic              r_we, w_we_nxt, r_is_if, w_is_if_nxt, r_live;
    logic [31:0]       r_wdata, w_wdata_nxt, r_rbuf, w_rbuf_nxt, w_acc;
    logic [31:0]       w_if_inst_nxt, w_mem_rdata_nxt;
    logic [7:0]        w_ram_dout_nxt, w_next_byte;
    logic              w_ram_wr_nxt, w_if_done_nxt, w_mem_done_nxt;
    logic [4:0]        w_sh;

    assign w_i_inc     = r_i + 3'd1;
    assign w_next_a    = r_addr + ADDR_W'(w_i_inc);
    assign w_next_byte = r_wdata[{w_i_inc[1:0], 3'b000} +: 8];
    assign w_sh        = {r_i[1:0] - 2'd1, 3'b000};
    assign w_mem_n     = (mem_len == 3'd1) ? 3'd1 : (mem_len == 3'd2) ? 3'd2 : 3'd4;

    // ram_din reflects the previous cycle's ram_a only if the last edge advanced;
    // after a freeze the byte was already captured on the first frozen cycle.
    assign w_acc = r_live ? (r_rbuf | ({24'd0, ram_din} << w_sh)) : r_rbuf;

    always_comb begin
        w_state_nxt     = r_state;
        w_i_nxt         = r_i;
        w_addr_nxt      = r_addr;
        w_we_nxt        = r_we;
        w_len_nxt       = r_len;
        w_wdata_nxt     = r_wdata;
        w_is_if_nxt     = r_is_if;
        w_rbuf_nxt      = r_rbuf;
        w_ram_a_nxt     = '0;
        w_ram_dout_nxt  = 8'd0;
        w_ram_wr_nxt    = 1'b0;
        w_if_done_nxt   = 1'b0;
        w_mem_done_nxt  = 1'b0;
        w_if_inst_nxt   = if_inst;
        w_mem_rdata_nxt = mem_rdata;
        case (r_state)
            S_IDLE: begin
                if (mem_req || if_req) begin
                    w_state_nxt = S_BUSY;
                    w_i_nxt     = 3'd0;
                    w_rbuf_nxt  = '0;
                    if (mem_req) begin
                        w_addr_nxt     = mem_addr;
                        w_we_nxt       = mem_we;
                        w_len_nxt      = w_mem_n;
                        w_wdata_nxt    = mem_wdata;
                        w_is_if_nxt    = 1'b0;
                        w_ram_a_nxt    = mem_addr;
                        w_ram_wr_nxt   = mem_we;
                        w_ram_dout_nxt = mem_we ? mem_wdata[7:0] : 8'd0;
                    end else begin
                        w_addr_nxt  = if_addr;
                        w_we_nxt    = 1'b0;
                        w_len_nxt   = 3'd4;
                        w_wdata_nxt = '0;
                        w_is_if_nxt = 1'b1;
                        w_ram_a_nxt = if_addr;
                    end
                end
            end
            S_BUSY: begin
                if (r_we) begin
                    if (w_i_inc < r_len) begin
                        w_i_nxt        = w_i_inc;
                        w_ram_a_nxt    = w_next_a;
                        w_ram_dout_nxt = w_next_byte;
                        w_ram_wr_nxt   = 1'b1;
                    end else begin
                        w_state_nxt    = S_DONE;
                        w_mem_done_nxt = 1'b1;
                    end
                end else begin
                    if (r_i != 3'd0) w_rbuf_nxt = w_acc;
                    if (r_i == r_len) begin
                        w_state_nxt = S_DONE;
                        if (r_is_if) begin
                            w_if_done_nxt = 1'b1;
                            w_if_inst_nxt = w_acc;
                        end else begin
                            w_mem_done_nxt  = 1'b1;
                            w_mem_rdata_nxt = w_acc;
                        end
                    end else begin
                        w_i_nxt = w_i_inc;
                        if (w_i_inc < r_len) w_ram_a_nxt = w_next_a;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_i_nxt     = 3'd0;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        r_live <= rdy;
        if (rst) begin
            r_state   <= S_IDLE;
            r_i       <= 3'd0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_len     <= 3'd0;
            r_wdata   <= '0;
            r_is_if   <= 1'b0;
            r_rbuf    <= '0;
            ram_a     <= '0;
            ram_dout  <= 8'd0;
            ram_wr    <= 1'b0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_inst   <= '0;
            mem_rdata <= '0;
        end else begin
            r_rbuf <= w_rbuf_nxt;
            if (rdy) begin
                r_state   <= w_state_nxt;
                r_i       <= w_i_nxt;
                r_addr    <= w_addr_nxt;
                r_we      <= w_we_nxt;
                r_len     <= w_len_nxt;
                r_wdata   <= w_wdata_nxt;
                r_is_if   <= w_is_if_nxt;
                ram_a     <= w_ram_a_nxt;
                ram_dout  <= w_ram_dout_nxt;
                ram_wr    <= w_ram_wr_nxt;
                if_done   <= w_if_done_nxt;
                mem_done  <= w_mem_done_nxt;
                if_inst   <= w_if_inst_nxt;
                mem_rdata <= w_mem_rdata_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Purpose  : Scenario bench for mem_ctrl with a byte RAM model and scoreboard.
// Revision : 1.0
// ============================================================================
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_inst;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [2:0]  mem_len = 3'd0;
    logic [31:0] mem_wdata = '0;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [7:0]  ram_din = 8'd0;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;

    logic [7:0]  ram [0:65535];
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    logic [31:0] exp_q[$];

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (ram_wr) ram[ram_a[15:0]] <= ram_dout;
        ram_din <= ram[ram_a[15:0]];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic wait_done(input int lim, output int dc, output bit gi, output bit gm);
        gi = 1'b0; gm = 1'b0; dc = -1;
        for (int k = 0; k < lim && !(gi || gm); k++) begin
            tick();
            gi = if_done; gm = mem_done; dc = cyc;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({if_done, mem_done, ram_wr, ram_a, ram_dout, if_inst, mem_rdata} !== '0)
            $display("FAIL reset_outputs: got %b/%b/%b a=%h d=%h inst=%h rdata=%h want all 0",
                     if_done, mem_done, ram_wr, ram_a, ram_dout, if_inst, mem_rdata);
        else passes++;
        rst = 1'b0;
    endtask

    task automatic test_fetch;
        int base, dc; bit gi, gm; logic [31:0] e;
        preload(16'h0100, 8'h13); preload(16'h0101, 8'h05);
        preload(16'h0102, 8'hA0); preload(16'h0103, 8'h00);
        if_addr = 32'h100; if_req = 1'b1;
        exp_q.push_back(32'h00A00513);
        base = cyc;
        for (int k = 0; k < 4; k++) begin
            tick();
            e = 32'h100 + 32'(k);
            checks++;
            if (ram_a !== e || ram_wr !== 1'b0)
                $display("FAIL fetch_addr%0d: got a=%h wr=%b want a=%h wr=0", k + 1, ram_a, ram_wr, e);
            else passes++;
        end
        wait_done(20, dc, gi, gm);
        if_req = 1'b0;
        checks++;
        if (!gi || gm || dc - base != 6)
            $display("FAIL fetch_done_cycle: got cycle %0d if=%b mem=%b want cycle 6 if only", dc - base, gi, gm);
        else passes++;
        e = exp_q.pop_front();
        checks++;
        if (if_inst !== e) $display("FAIL fetch_inst: got %h want %h", if_inst, e);
        else passes++;
    endtask

    task automatic test_store;
        int base, dc; bit gi, gm;
        preload(16'h2000, 8'h77); preload(16'h1FFE, 8'h00); preload(16'h1FFF, 8'h00);
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 3'd2; mem_addr = 32'h1FFE; mem_wdata = 32'hDEADBEEF;
        base = cyc;
        tick();
        checks++;
        if ({ram_wr, ram_a, ram_dout} !== {1'b1, 32'h1FFE, 8'hEF})
            $display("FAIL store_c1: got wr=%b a=%h d=%h want 1/00001ffe/ef", ram_wr, ram_a, ram_dout);
        else passes++;
        tick();
        checks++;
        if ({ram_wr, ram_a, ram_dout} !== {1'b1, 32'h1FFF, 8'hBE})
            $display("FAIL store_c2: got wr=%b a=%h d=%h want 1/00001fff/be", ram_wr, ram_a, ram_dout);
        else passes++;
        wait_done(20, dc, gi, gm);
        mem_req = 1'b0;
        checks++;
        if (!gm || gi || dc - base != 3 || ram_wr !== 1'b0)
            $display("FAIL store_done: got cycle %0d mem=%b if=%b wr=%b want cycle 3 mem, wr=0", dc - base, gm, gi, ram_wr);
        else passes++;
        tick();
        checks++;
        if ({ram[16'h1FFE], ram[16'h1FFF], ram[16'h2000]} !== {8'hEF, 8'hBE, 8'h77})
            $display("FAIL store_ram: got %h %h %h want ef be 77", ram[16'h1FFE], ram[16'h1FFF], ram[16'h2000]);
        else passes++;
    endtask

    task automatic test_priority;
        int base, dc; bit gi, gm; logic [31:0] e;
        preload(16'h0020, 8'h85);
        preload(16'h0024, 8'h78); preload(16'h0025, 8'h56);
        preload(16'h0026, 8'h34); preload(16'h0027, 8'h12);
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 3'd1; mem_addr = 32'h20;
        if_req = 1'b1; if_addr = 32'h24;
        exp_q.push_back(32'h00000085);
        exp_q.push_back(32'h12345678);
        base = cyc;
        wait_done(20, dc, gi, gm);
        mem_req = 1'b0;
        checks++;
        if (!gm || gi || dc - base != 3)
            $display("FAIL prio_mem_done: got cycle %0d mem=%b if=%b want cycle 3 mem only", dc - base, gm, gi);
        else passes++;
        e = exp_q.pop_front();
        checks++;
        if (mem_rdata !== e) $display("FAIL prio_mem_rdata: got %h want %h", mem_rdata, e);
        else passes++;
        wait_done(20, dc, gi, gm);
        if_req = 1'b0;
        checks++;
        if (!gi || gm || dc - base != 10)
            $display("FAIL prio_if_done: got cycle %0d if=%b mem=%b want cycle 10 if only", dc - base, gi, gm);
        else passes++;
        e = exp_q.pop_front();
        checks++;
        if (if_inst !== e || mem_rdata !== 32'h85)
            $display("FAIL prio_if_inst: got inst=%h rdata=%h want inst=%h rdata=00000085", if_inst, mem_rdata, e);
        else passes++;
    endtask

    task automatic test_len;
        int base, dc; bit gi, gm; logic [31:0] e;
        preload(16'h0040, 8'hA1); preload(16'h0041, 8'hB2); preload(16'h0042, 8'hC3);
        preload(16'h0043, 8'hD4); preload(16'h0044, 8'h5A); preload(16'h0045, 8'h6B);
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 3'd3; mem_addr = 32'h40;
        exp_q.push_back(32'hD4C3B2A1);
        base = cyc;
        wait_done(20, dc, gi, gm);
        mem_req = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (!gm || dc - base != 6 || mem_rdata !== e)
            $display("FAIL len3_as_word: got cycle %0d rdata=%h want cycle 6 rdata=%h", dc - base, mem_rdata, e);
        else passes++;
        tick();
        mem_req = 1'b1; mem_len = 3'd2; mem_addr = 32'h44;
        exp_q.push_back(32'h00006B5A);
        base = cyc;
        wait_done(20, dc, gi, gm);
        mem_req = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (!gm || dc - base != 4 || mem_rdata !== e)
            $display("FAIL len2_zext: got cycle %0d rdata=%h want cycle 4 rdata=%h", dc - base, mem_rdata, e);
        else passes++;
        tick(); tick();
        checks++;
        if (mem_rdata !== e || mem_done !== 1'b0)
            $display("FAIL rdata_hold: got rdata=%h done=%b want %h done=0", mem_rdata, mem_done, e);
        else passes++;
    endtask

    task automatic test_wrap_read;
        int base, dc; bit gi, gm; logic [31:0] e;
        preload(16'hFFFE, 8'hAA); preload(16'hFFFF, 8'hBB);
        preload(16'h0000, 8'hCC); preload(16'h0001, 8'hDD);
        if_addr = 32'hFFFFFFFE; if_req = 1'b1;
        exp_q.push_back(32'hDDCCBBAA);
        base = cyc;
        for (int k = 0; k < 4; k++) begin
            tick();
            e = 32'hFFFFFFFE + 32'(k);
            checks++;
            if (ram_a !== e) $display("FAIL wrap_addr%0d: got %h want %h", k + 1, ram_a, e);
            else passes++;
        end
        wait_done(20, dc, gi, gm);
        if_req = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (!gi || dc - base != 6 || if_inst !== e)
            $display("FAIL wrap_inst: got cycle %0d inst=%h want cycle 6 inst=%h", dc - base, if_inst, e);
        else passes++;
    endtask

    task automatic test_reset_mid;
        int base, dc; bit gi, gm; logic [31:0] e;
        for (int k = 0; k < 4; k++) preload(16'h0300 + 16'(k), 8'h00);
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 3'd4; mem_addr = 32'h300; mem_wdata = 32'h11223344;
        tick(); tick();
        checks++;
        if ({ram_wr, ram_a, ram_dout} !== {1'b1, 32'h301, 8'h33})
            $display("FAIL rstmid_c2: got wr=%b a=%h d=%h want 1/00000301/33", ram_wr, ram_a, ram_dout);
        else passes++;
        rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
        tick();
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h24;
        exp_q.push_back(32'h12345678);
        base = cyc;
        checks++;
        if (ram_wr !== 1'b0 || ram_a !== 32'h0 || mem_done !== 1'b0)
            $display("FAIL rstmid_c3: got wr=%b a=%h done=%b want 0/0/0", ram_wr, ram_a, mem_done);
        else passes++;
        tick();
        checks++;
        if (ram_a !== 32'h24) $display("FAIL rstmid_accept: got a=%h want 00000024", ram_a);
        else passes++;
        wait_done(20, dc, gi, gm);
        if_req = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (!gi || gm || dc - base != 6 || if_inst !== e)
            $display("FAIL rstmid_fetch: got cycle %0d if=%b mem=%b inst=%h want cycle 6 if only inst=%h",
                     dc - base, gi, gm, if_inst, e);
        else passes++;
        checks++;
        if ({ram[16'h0300], ram[16'h0301], ram[16'h0302], ram[16'h0303]} !== 32'h44330000)
            $display("FAIL rstmid_ram: got %h %h %h %h want 44 33 00 00",
                     ram[16'h0300], ram[16'h0301], ram[16'h0302], ram[16'h0303]);
        else passes++;
    endtask

    task automatic test_freeze;
        int base, dc; bit gi, gm; logic [31:0] e;
        logic [31:0] ea [1:7];
        ea = '{32'h200, 32'h201, 32'h201, 32'h201, 32'h201, 32'h202, 32'h203};
        preload(16'h0200, 8'h11); preload(16'h0201, 8'h22);
        preload(16'h0202, 8'h33); preload(16'h0203, 8'h44);
        if_addr = 32'h200; if_req = 1'b1;
        exp_q.push_back(32'h44332211);
        base = cyc;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++;
            if (ram_a !== ea[k]) $display("FAIL freeze_addr%0d: got %h want %h", k, ram_a, ea[k]);
            else passes++;
            if (k == 2) rdy = 1'b0;
            if (k == 5) rdy = 1'b1;
        end
        wait_done(20, dc, gi, gm);
        e = exp_q.pop_front();
        checks++;
        if (!gi || dc - base != 9 || if_inst !== e)
            $display("FAIL freeze_done: got cycle %0d inst=%h want cycle 9 inst=%h", dc - base, if_inst, e);
        else passes++;
        rdy = 1'b0;
        tick();
        checks++;
        if (if_done !== 1'b1 || mem_done !== 1'b0)
            $display("FAIL freeze_pulse_ext: got if_done=%b mem_done=%b want 1/0", if_done, mem_done);
        else passes++;
        rdy = 1'b1; if_req = 1'b0;
        tick(); tick();
        checks++;
        if (if_done !== 1'b0 || if_inst !== e)
            $display("FAIL inst_hold: got done=%b inst=%h want 0/%h", if_done, if_inst, e);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_priority();
        test_len();
        test_wrap_read();
        test_reset_mid();
        test_freeze();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
